// File: rtl/jt9346_dump_seq.sv
// ----------------------------------------------------------------------------
// jt9346_dump_seq
//   Sequences the 8-bit dump port of the jt9346 EEPROM wrapper for the host
//   NVRAM path.
//   - Load: streams 2**AW bytes from the host into the EEPROM.
//   - Save: streams 2**AW bytes out of the EEPROM to the host.
//   - Loads and saves never overlap. The module also manages the wrapper's
//     "contents changed" flag.
//
// Optional feature macro: JT9346_AUTOSAVE_EN
//   Defined   : a TOUT_W-bit idle timer raises autosave_req once dump_flag
//               has been high for 2**TOUT_W-1 consecutive idle cycles.
//   Undefined : no timer; autosave_req is tied to 0.
//
// Parameters
//   AW     dump byte-address width (one transfer = 2**AW bytes)
//   DLY    cycles from a dump_addr change to valid dump_dout (1..7)
//   TOUT_W autosave idle-timer width
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   ld_start/valid/data   host load request and byte stream (ld_ready back)
//   sv_start/ready        host save request and byte sink (sv_valid/data out)
//   busy, done            transfer in progress / one-cycle end pulse
//   autosave_req          asks the host to issue sv_start
//   dump_addr/we/din      EEPROM wrapper byte address, write strobe, data
//   dump_dout             EEPROM wrapper read data
//   dump_clr              one-cycle clear of the wrapper change flag
//   dump_flag             EEPROM contents were changed by the game
// ----------------------------------------------------------------------------
module jt9346_dump_seq #(
    parameter int AW     = 7,
    parameter int DLY    = 2,
    parameter int TOUT_W = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    input  logic          sv_start,
    output logic          sv_valid,
    output logic [7:0]    sv_data,
    input  logic          sv_ready,
    output logic          busy,
    output logic          done,
    output logic          autosave_req,
    output logic [AW-1:0] dump_addr,
    output logic          dump_we,
    output logic [7:0]    dump_din,
    input  logic [7:0]    dump_dout,
    output logic          dump_clr,
    input  logic          dump_flag
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        LGAP = 3'd2,
        RD   = 3'd3,
        OUT  = 3'd4,
        FIN  = 3'd5
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = '1;
    localparam logic [2:0]    DLY_END   = 3'(DLY);

    state_t          state_q,    state_d;
    logic [AW-1:0]   count_q,    count_d;
    logic [2:0]      dly_q,      dly_d;
    logic            ld_ready_q, ld_ready_d;
    logic            sv_valid_q, sv_valid_d;
    logic [7:0]      sv_data_q,  sv_data_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    logic            dump_we_q,  dump_we_d;
    logic [7:0]      dump_din_q, dump_din_d;
    logic            dump_clr_q, dump_clr_d;

    // Next-state and next-output logic. Every output is registered so the
    // host and the wrapper only ever see flop outputs.
    always_comb begin
        // NOTE: every _d gets a default before the case, so no path can leave
        // one unassigned and infer a latch.
        state_d    = state_q;
        count_d    = count_q;
        dly_d      = dly_q;
        ld_ready_d = 1'b0;
        sv_valid_d = sv_valid_q;
        sv_data_d  = sv_data_q;
        dump_we_d  = 1'b0;
        dump_din_d = dump_din_q;
        dump_clr_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Load has priority; a simultaneous sv_start is dropped.
                if (ld_start) begin
                    state_d    = LOAD;
                    count_d    = '0;
                    ld_ready_d = 1'b1;
                end else if (sv_start) begin
                    state_d    = RD;
                    count_d    = '0;
                    dly_d      = '0;
                    // Clear at save start so game writes during the save re-flag.
                    dump_clr_d = 1'b1;
                end
            end
            LOAD: begin
                // ld_ready is high throughout LOAD, so ld_valid alone accepts.
                if (ld_valid) begin
                    state_d    = LGAP;
                    dump_we_d  = 1'b1;
                    dump_din_d = ld_data;
                end else begin
                    ld_ready_d = 1'b1;
                end
            end
            LGAP: begin
                // One dead cycle per byte: the 16-bit wrapper latches here.
                count_d = count_q + 1'b1;
                if (count_q == LAST_ADDR) begin
                    state_d    = FIN;
                    // Freshly loaded data must not read back as "changed".
                    dump_clr_d = 1'b1;
                end else begin
                    state_d    = LOAD;
                    ld_ready_d = 1'b1;
                end
            end
            RD: begin
                // dump_addr changed on RD entry; dump_dout is valid from the
                // DLY-th cycle after, which is the cycle it gets captured.
                if (dly_q == DLY_END) begin
                    sv_data_d  = dump_dout;
                    sv_valid_d = 1'b1;
                    state_d    = OUT;
                end else begin
                    dly_d = dly_q + 3'd1;
                end
            end
            OUT: begin
                if (sv_ready) begin
                    sv_valid_d = 1'b0;
                    count_d    = count_q + 1'b1;
                    dly_d      = '0;
                    state_d    = (count_q == LAST_ADDR) ? FIN : RD;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            dly_q      <= '0;
            ld_ready_q <= 1'b0;
            sv_valid_q <= 1'b0;
            sv_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dump_we_q  <= 1'b0;
            dump_din_q <= '0;
            dump_clr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            dly_q      <= dly_d;
            ld_ready_q <= ld_ready_d;
            sv_valid_q <= sv_valid_d;
            sv_data_q  <= sv_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dump_we_q  <= dump_we_d;
            dump_din_q <= dump_din_d;
            dump_clr_q <= dump_clr_d;
        end
    end

`ifdef JT9346_AUTOSAVE_EN
    logic [TOUT_W-1:0] timer_q, timer_d;
    logic              autosave_req_q, autosave_req_d;

    // Counts idle cycles with dirty contents; saturates at all ones. Clearing
    // on state_d means the request drops right after sv_start is accepted.
    always_comb begin
        timer_d = timer_q;
        if (state_d != IDLE || !dump_flag) begin
            timer_d = '0;
        end else if (!(&timer_q)) begin
            timer_d = timer_q + 1'b1;
        end
        autosave_req_d = &timer_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q        <= '0;
            autosave_req_q <= 1'b0;
        end else begin
            timer_q        <= timer_d;
            autosave_req_q <= autosave_req_d;
        end
    end

    assign autosave_req = autosave_req_q;
`else
    // dump_flag and TOUT_W only feed the idle timer, which is not built.
    logic unused_cfg;
    assign unused_cfg   = &{1'b0, dump_flag, TOUT_W[0]};
    assign autosave_req = 1'b0;
`endif

    assign ld_ready  = ld_ready_q;
    assign sv_valid  = sv_valid_q;
    assign sv_data   = sv_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dump_addr = count_q;
    assign dump_we   = dump_we_q;
    assign dump_din  = dump_din_q;
    assign dump_clr  = dump_clr_q;

endmodule
